// File: rtl/sc_lfsr_sng.sv
// rtl/sc_lfsr_sng.sv - LFSR-based stochastic number generator with NUM_CH decorrelated channels
//
// Purpose: one maximal-length Fibonacci LFSR feeds NUM_CH rotated / optionally
// bit-reversed views. Each view is compared against a captured per-channel operand
// to emit one stochastic bit per channel for LEN samples per stream.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   start      stream start request, sampled in IDLE only
//   seed_load  load seed into LFSR, honoured in IDLE only (seed=0 loads SEED_DEFAULT)
//   seed       seed value
//   enable     advance qualifier while running; low stalls the stream
//   x_in       channel operands, channel k at [k*WIDTH +: WIDTH]
//   rnd_out    registered random words, same packing as x_in
//   sc_bit     registered stochastic bits, one per channel
//   valid      rnd_out/sc_bit carry a new sample this cycle
//   busy       high while a stream is running or finishing
//   done       one-cycle pulse after the final sample
module sc_lfsr_sng #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 'h71,
  parameter int               NUM_CH       = 2,
  parameter int               ROT          = 3,
  parameter int               FLIP_ODD     = 1,
  parameter int               LEN          = 255,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 'h80
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    seed_load,
  input  logic [WIDTH-1:0]        seed,
  input  logic                    enable,
  input  logic [NUM_CH*WIDTH-1:0] x_in,
  output logic [NUM_CH*WIDTH-1:0] rnd_out,
  output logic [NUM_CH-1:0]       sc_bit,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LEN - 1);

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        lfsr_q, lfsr_d;
  logic [WIDTH-1:0]        cnt_q, cnt_d;
  logic [NUM_CH*WIDTH-1:0] x_cap_q, x_cap_d;
  logic [NUM_CH*WIDTH-1:0] rnd_q, rnd_d;
  logic [NUM_CH-1:0]       sc_q, sc_d;
  logic                    valid_q, busy_q, done_q;

  logic                    lockup, sample, last_sample, fb;
  logic [NUM_CH*WIDTH-1:0] view_all;
  logic [NUM_CH-1:0]       lt_w;

  assign fb = ^(lfsr_q & TAPS);

  // Per-channel view: left-rotate by (k*ROT) mod WIDTH, then reverse odd channels.
  // Both are pure rewiring, so every view is a bijection of the LFSR state.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam int R = (k * ROT) % WIDTH;
    logic [WIDTH-1:0] rot_w;
    logic [WIDTH-1:0] view_w;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign rot_w[(i + R) % WIDTH] = lfsr_q[i];
      if (FLIP_ODD != 0 && (k % 2) == 1) begin : g_flip
        assign view_w[i] = rot_w[WIDTH-1-i];
      end else begin : g_pass
        assign view_w[i] = rot_w[i];
      end
    end
    assign view_all[k*WIDTH +: WIDTH] = view_w;
    assign lt_w[k] = (view_w < x_cap_q[k*WIDTH +: WIDTH]);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_sample) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath next values
  always_comb begin
    // An all-zero LFSR would stick; recovering from it never counts as a sample.
    lockup      = (lfsr_q == '0);
    sample      = (state_q == S_RUN) && enable && !lockup;
    last_sample = sample && (cnt_q == LAST);

    lfsr_d = lfsr_q;
    if (lockup)
      lfsr_d = SEED_DEFAULT;
    else if (state_q == S_IDLE && seed_load)
      lfsr_d = (seed == '0) ? SEED_DEFAULT : seed;
    else if (sample)
      lfsr_d = {fb, lfsr_q[WIDTH-1:1]};

    cnt_d = cnt_q;
    if (sample) cnt_d = last_sample ? '0 : cnt_q + 1'b1;

    x_cap_d = x_cap_q;
    if (state_q == S_IDLE && start) x_cap_d = x_in;

    rnd_d = rnd_q;
    sc_d  = sc_q;
    if (sample) begin
      rnd_d = view_all;
      sc_d  = lt_w;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= SEED_DEFAULT;
      cnt_q   <= '0;
      x_cap_q <= '0;
      rnd_q   <= '0;
      sc_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      x_cap_q <= x_cap_d;
      rnd_q   <= rnd_d;
      sc_q    <= sc_d;
      valid_q <= sample;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_q == S_DONE);
    end
  end

  assign rnd_out = rnd_q;
  assign sc_bit  = sc_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
